pe_scheduler: RTL and testbench

- Sequencer that drives one single-MAC processing element (PE) across a full image convolution.
- Loads the KxK filter from filter memory once, then fills and slides the PE's picture window across the image row by row from image memory.
- Starts the PE for each window and hands each 8-bit result to a downstream consumer through a valid/ready handshake.
- Sits between the image/filter memories and the PE.

---
 rtl/pe_scheduler.sv | 257 +++++++++++++++++++++++++
 tb/tb_pe_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_scheduler.sv
// Sequencer driving a single-MAC PE across a full image convolution.
// Optional stall counter enabled by defining PE_SCHED_STALL_CNT_EN.
module pe_scheduler #(
  parameter int KERNEL_SIZE = 4,
  parameter int IMG_W       = 16,
  parameter int IMG_H       = 16,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              reload_fil,
  output logic              busy,
  output logic              done,
  output logic              fil_rd_en,
  output logic [ADDR_W-1:0] fil_rd_addr,
  input  logic [7:0]        fil_rd_data,
  output logic              img_rd_en,
  output logic [ADDR_W-1:0] img_rd_addr,
  input  logic [7:0]        img_rd_data,
  output logic              pe_start,
  output logic              pe_pic_wr_en,
  output logic              pe_filter_wr_en,
  output logic              pe_shift_left,
  output logic              pe_shift_up,
  output logic [31:0]       pe_idx_i,
  output logic [31:0]       pe_idx_j,
  output logic [7:0]        pe_fil_data,
  output logic [7:0]        pe_buf_data,
  input  logic              pe_done,
  input  logic [7:0]        pe_data_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [7:0]        res_data,
  output logic [31:0]       res_row,
  output logic [31:0]       res_col,
  output logic [31:0]       stall_cnt
);

  localparam logic [31:0] K        = 32'(KERNEL_SIZE);
  localparam logic [31:0] KK       = 32'(KERNEL_SIZE * KERNEL_SIZE);
  localparam logic [31:0] W        = 32'(IMG_W);
  localparam logic [31:0] COL_LAST = 32'(IMG_W - KERNEL_SIZE);
  localparam logic [31:0] ROW_LAST = 32'(IMG_H - KERNEL_SIZE);

  typedef enum logic [3:0] {
    IDLE, LOAD_FIL, LOAD_WIN, SHIFT, LOAD_COL, RUN, WAIT_PE, OUT, FIN
  } state_t;

  state_t      state;
  logic        filter_loaded;
  logic [31:0] row, col, ri, rj, cnt;
  logic [31:0] ni, nj;

  function automatic logic [ADDR_W-1:0] fil_addr(input logic [31:0] i, input logic [31:0] j);
    logic [31:0] a;
    a = i * K + j;
    return a[ADDR_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] img_addr(input logic [31:0] r, input logic [31:0] c);
    logic [31:0] a;
    a = r * W + c;
    return a[ADDR_W-1:0];
  endfunction

  // Next (i,j) of a full-window walk, i-major.
  always_comb begin
    ni = ri;
    nj = rj + 32'd1;
    if (rj == K - 32'd1) begin
      ni = ri + 32'd1;
      nj = '0;
    end
  end

  // Memory output register already stages the data; the read issued in cycle t
  // is written in t+1, so the write buses are gated copies that idle at 0.
  assign pe_fil_data = pe_filter_wr_en ? fil_rd_data : '0;
  assign pe_buf_data = pe_pic_wr_en    ? img_rd_data : '0;
  assign pe_shift_up = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      filter_loaded   <= 1'b0;
      row             <= '0;
      col             <= '0;
      ri              <= '0;
      rj              <= '0;
      cnt             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      fil_rd_en       <= 1'b0;
      fil_rd_addr     <= '0;
      img_rd_en       <= 1'b0;
      img_rd_addr     <= '0;
      pe_start        <= 1'b0;
      pe_pic_wr_en    <= 1'b0;
      pe_filter_wr_en <= 1'b0;
      pe_shift_left   <= 1'b0;
      pe_idx_i        <= '0;
      pe_idx_j        <= '0;
      res_valid       <= 1'b0;
      res_data        <= '0;
      res_row         <= '0;
      res_col         <= '0;
    end else begin
      fil_rd_en       <= 1'b0;
      img_rd_en       <= 1'b0;
      pe_filter_wr_en <= 1'b0;
      pe_pic_wr_en    <= 1'b0;
      pe_shift_left   <= 1'b0;
      pe_start        <= 1'b0;
      done            <= 1'b0;
      pe_idx_i        <= '0;
      pe_idx_j        <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            row  <= '0;
            col  <= '0;
            ri   <= '0;
            rj   <= '0;
            cnt  <= '0;
            if (reload_fil || !filter_loaded) begin
              state       <= LOAD_FIL;
              fil_rd_en   <= 1'b1;
              fil_rd_addr <= fil_addr('0, '0);
            end else begin
              state       <= LOAD_WIN;
              img_rd_en   <= 1'b1;
              img_rd_addr <= img_addr('0, '0);
            end
          end
        end
        LOAD_FIL: begin
          cnt <= cnt + 32'd1;
          if (fil_rd_en) begin
            pe_filter_wr_en <= 1'b1;
            pe_idx_i        <= ri;
            pe_idx_j        <= rj;
            if (cnt + 32'd1 < KK) begin
              fil_rd_en   <= 1'b1;
              fil_rd_addr <= fil_addr(ni, nj);
              ri          <= ni;
              rj          <= nj;
            end
          end
          if (cnt == KK) begin
            filter_loaded <= 1'b1;
            state         <= LOAD_WIN;
            img_rd_en     <= 1'b1;
            img_rd_addr   <= img_addr(row, col);
            ri            <= '0;
            rj            <= '0;
            cnt           <= '0;
          end
        end
        LOAD_WIN: begin
          cnt <= cnt + 32'd1;
          if (img_rd_en) begin
            pe_pic_wr_en <= 1'b1;
            pe_idx_i     <= ri;
            pe_idx_j     <= rj;
            if (cnt + 32'd1 < KK) begin
              img_rd_en   <= 1'b1;
              img_rd_addr <= img_addr(row + ni, col + nj);
              ri          <= ni;
              rj          <= nj;
            end
          end
          if (cnt == KK) begin
            state    <= RUN;
            pe_start <= 1'b1;
          end
        end
        SHIFT: begin
          state       <= LOAD_COL;
          img_rd_en   <= 1'b1;
          img_rd_addr <= img_addr(row, col + K - 32'd1);
          ri          <= '0;
          rj          <= K - 32'd1;
          cnt         <= '0;
        end
        LOAD_COL: begin
          cnt <= cnt + 32'd1;
          if (img_rd_en) begin
            pe_pic_wr_en <= 1'b1;
            pe_idx_i     <= ri;
            pe_idx_j     <= rj;
            if (cnt + 32'd1 < K) begin
              img_rd_en   <= 1'b1;
              img_rd_addr <= img_addr(row + ri + 32'd1, col + rj);
              ri          <= ri + 32'd1;
            end
          end
          if (cnt == K) begin
            state    <= RUN;
            pe_start <= 1'b1;
          end
        end
        RUN: state <= WAIT_PE;
        WAIT_PE: begin
          if (pe_done) begin
            res_data  <= pe_data_out;
            res_valid <= 1'b1;
            res_row   <= row;
            res_col   <= col;
            state     <= OUT;
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (col < COL_LAST) begin
              col           <= col + 32'd1;
              state         <= SHIFT;
              pe_shift_left <= 1'b1;
            end else if (row < ROW_LAST) begin
              row         <= row + 32'd1;
              col         <= '0;
              state       <= LOAD_WIN;
              img_rd_en   <= 1'b1;
              img_rd_addr <= img_addr(row + 32'd1, '0);
              ri          <= '0;
              rj          <= '0;
              cnt         <= '0;
            end else begin
              state <= FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PE_SCHED_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (state == IDLE && start) begin
      stall_cnt <= '0;
    end else if (res_valid && !res_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pe_scheduler.sv
// Directed bench for pe_scheduler: K=2 over a 3x3 image, all-ones filter, summing PE model.
module tb_pe_scheduler;

  localparam int K  = 2;
  localparam int W  = 3;
  localparam int H  = 3;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          reload_fil = 1'b0;
  logic          busy, done;
  logic          fil_rd_en, img_rd_en;
  logic [AW-1:0] fil_rd_addr, img_rd_addr;
  logic [7:0]    fil_rd_data = '0;
  logic [7:0]    img_rd_data = '0;
  logic          pe_start, pe_pic_wr_en, pe_filter_wr_en, pe_shift_left, pe_shift_up;
  logic [31:0]   pe_idx_i, pe_idx_j;
  logic [7:0]    pe_fil_data, pe_buf_data;
  logic          pe_done;
  logic [7:0]    pe_data_out;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [7:0]    res_data;
  logic [31:0]   res_row, res_col, stall_cnt;

  always #5 clk = ~clk;

  pe_scheduler #(.KERNEL_SIZE(K), .IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .reload_fil(reload_fil),
    .busy(busy), .done(done),
    .fil_rd_en(fil_rd_en), .fil_rd_addr(fil_rd_addr), .fil_rd_data(fil_rd_data),
    .img_rd_en(img_rd_en), .img_rd_addr(img_rd_addr), .img_rd_data(img_rd_data),
    .pe_start(pe_start), .pe_pic_wr_en(pe_pic_wr_en), .pe_filter_wr_en(pe_filter_wr_en),
    .pe_shift_left(pe_shift_left), .pe_shift_up(pe_shift_up),
    .pe_idx_i(pe_idx_i), .pe_idx_j(pe_idx_j),
    .pe_fil_data(pe_fil_data), .pe_buf_data(pe_buf_data),
    .pe_done(pe_done), .pe_data_out(pe_data_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_row(res_row), .res_col(res_col), .stall_cnt(stall_cnt)
  );

  // Memories with one cycle read latency.
  logic [7:0] img_mem [16];
  logic [7:0] fil_mem [4];
  always @(posedge clk) begin
    if (fil_rd_en) fil_rd_data <= fil_mem[fil_rd_addr[1:0]];
    if (img_rd_en) img_rd_data <= img_mem[img_rd_addr[3:0]];
  end

  // PE model: sum of window*filter, reported 4 cycles after pe_start.
  logic [7:0] pic [2][2];
  logic [7:0] fil [2][2];
  logic [7:0] acc;
  int unsigned cd;
  logic model_done;
  logic [7:0] model_data;
  logic inj_done = 1'b0;

  function automatic logic [7:0] win_sum();
    int s;
    s = 0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        s += int'(pic[i][j]) * int'(fil[i][j]);
    return 8'(s);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cd         <= 0;
      model_done <= 1'b0;
      model_data <= '0;
      acc        <= '0;
    end else begin
      model_done <= 1'b0;
      if (pe_filter_wr_en) fil[pe_idx_i[0]][pe_idx_j[0]] <= pe_fil_data;
      if (pe_pic_wr_en) pic[pe_idx_i[0]][pe_idx_j[0]] <= pe_buf_data;
      if (pe_shift_left) begin
        pic[0][0] <= pic[0][1];
        pic[1][0] <= pic[1][1];
      end
      if (pe_start) begin
        acc <= win_sum();
        cd  <= 4;
      end else if (cd != 0) begin
        cd <= cd - 1;
        if (cd == 1) begin
          model_done <= 1'b1;
          model_data <= acc;
        end
      end
    end
  end

  assign pe_done     = model_done | inj_done;
  assign pe_data_out = inj_done ? 8'hAA : model_data;

  // Event counters, free running; runs compare deltas.
  int unsigned n_fil_rd = 0, n_fil_wr = 0, n_pic_wr = 0, n_shift = 0, n_pe_start = 0, n_done = 0;
  always @(posedge clk) begin
    if (fil_rd_en)       n_fil_rd   <= n_fil_rd + 1;
    if (pe_filter_wr_en) n_fil_wr   <= n_fil_wr + 1;
    if (pe_pic_wr_en)    n_pic_wr   <= n_pic_wr + 1;
    if (pe_shift_left)   n_shift    <= n_shift + 1;
    if (pe_start)        n_pe_start <= n_pe_start + 1;
    if (done)            n_done     <= n_done + 1;
  end

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned b_fr, b_fw, b_pw, b_sh, b_ps, b_dn;

  typedef struct {
    int unsigned hold;
    logic [7:0]  data;
    logic [31:0] row;
    logic [31:0] col;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out, got no event, expected one", name);
  endtask

  task automatic snapshot();
    b_fr = n_fil_rd; b_fw = n_fil_wr; b_pw = n_pic_wr;
    b_sh = n_shift;  b_ps = n_pe_start; b_dn = n_done;
  endtask

  task automatic start_run(input logic reload);
    @(negedge clk);
    start = 1'b1;
    reload_fil = reload;
    @(negedge clk);
    start = 1'b0;
    reload_fil = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic run_vectors(input int unsigned first_hold);
    int unsigned hold;
    bit ok;
    res_ready = (first_hold == 0);
    for (int v = 0; v < 4; v++) begin
      hold = (v == 0) ? first_hold : vecs[v].hold;
      ok = 0;
      for (int t = 0; t < 200 && !ok; t++) begin
        if (res_valid) ok = 1;
        else @(negedge clk);
      end
      if (!ok) begin
        timeout($sformatf("res_valid[%0d]", v));
        return;
      end
      check($sformatf("res_data[%0d]", v), res_data, vecs[v].data);
      check($sformatf("res_row[%0d]", v), res_row, vecs[v].row);
      check($sformatf("res_col[%0d]", v), res_col, vecs[v].col);
      if (hold > 0) begin
        for (int h = 0; h < int'(hold); h++) begin
          @(negedge clk);
          check("hold_valid", res_valid, 1);
          check("hold_data", res_data, vecs[v].data);
        end
        res_ready = 1'b1;
      end
      @(negedge clk);
    end
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      if (done) ok = 1;
      else @(negedge clk);
    end
    if (!ok) begin
      timeout("done");
      return;
    end
    check("busy_at_done", busy, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  task automatic glitch();
    bit seen;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (pe_pic_wr_en) seen = 1;
    end
    if (!seen) begin
      timeout("load_win_seen");
      return;
    end
    start = 1'b1;
    reload_fil = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reload_fil = 1'b0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (pe_shift_left) seen = 1;
    end
    if (!seen) begin
      timeout("shift_seen");
      return;
    end
    @(negedge clk);
    check("in_load_col", img_rd_en, 1);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    vecs[0] = '{hold: 0, data: 8'd8,  row: 32'd0, col: 32'd0};
    vecs[1] = '{hold: 0, data: 8'd12, row: 32'd0, col: 32'd1};
    vecs[2] = '{hold: 0, data: 8'd20, row: 32'd1, col: 32'd0};
    vecs[3] = '{hold: 0, data: 8'd24, row: 32'd1, col: 32'd1};
    for (int i = 0; i < 16; i++) img_mem[i] = 8'(i);
    for (int i = 0; i < 4; i++) fil_mem[i] = 8'd1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_strobes", {fil_rd_en, img_rd_en, pe_start, pe_pic_wr_en, pe_filter_wr_en, pe_shift_left, pe_shift_up}, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_buses", |{fil_rd_addr, img_rd_addr, pe_idx_i, pe_idx_j, res_data, res_row, res_col, stall_cnt}, 0);
    rst = 1'b1;
    @(negedge clk);

    // Full run with filter load
    snapshot();
    start_run(1'b1);
    run_vectors(0);
    check("r1_fil_rd", n_fil_rd - b_fr, 4);
    check("r1_fil_wr", n_fil_wr - b_fw, 4);
    check("r1_pic_wr", n_pic_wr - b_pw, 12);
    check("r1_shift", n_shift - b_sh, 2);
    check("r1_pe_start", n_pe_start - b_ps, 4);
    check("r1_done", n_done - b_dn, 1);

    // Reuse loaded filter, stall first result 5 cycles
    snapshot();
    start_run(1'b0);
    run_vectors(5);
    check("r2_fil_rd", n_fil_rd - b_fr, 0);
    check("r2_pic_wr", n_pic_wr - b_pw, 12);
`ifdef PE_SCHED_STALL_CNT_EN
    check("r2_stall_cnt", stall_cnt, 5);
`else
    check("r2_stall_cnt", stall_cnt, 0);
`endif

    // Reset during WAIT_PE of second window
    res_ready = 1'b1;
    snapshot();
    start_run(1'b0);
    ok = 0;
    for (int t = 0; t < 300 && !ok; t++) begin
      if (n_pe_start - b_ps == 2) ok = 1;
      else @(negedge clk);
    end
    if (!ok) timeout("second_pe_start");
    #1 rst = 1'b0;
    #1;
    check("abort_ctrl", {busy, done, res_valid, fil_rd_en, img_rd_en, pe_start, pe_pic_wr_en, pe_filter_wr_en, pe_shift_left}, 0);
    check("abort_buses", |{fil_rd_addr, img_rd_addr, pe_idx_i, pe_idx_j, res_data, res_row, res_col, stall_cnt, pe_fil_data, pe_buf_data}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    snapshot();
    start_run(1'b0);
    run_vectors(0);
    check("r3_fil_reload", n_fil_rd - b_fr, 4);
    check("r3_fil_wr", n_fil_wr - b_fw, 4);

    // Start during LOAD_WIN and stray pe_done in LOAD_COL are ignored
    snapshot();
    start_run(1'b0);
    fork
      run_vectors(0);
      glitch();
    join
    check("r4_fil_rd", n_fil_rd - b_fr, 0);
    check("r4_pe_start", n_pe_start - b_ps, 4);
    check("r4_done", n_done - b_dn, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
